ram_loader: RTL
===============

Name: ram_loader

Overview:
- Writer-side counterpart to the 16x8 program RAM: receives a framed byte stream and loads RAM through the shared bus before the CPU runs.
- While loading, it holds the CPU in reset. It drives the bus as an external source and pulses the RAM address-write and data-write strobes.
- Replaces testbench-only memory preloading, so programs can be loaded from a host or UART front end.

Parameters:
- DEPTH, 16, number of RAM words; legal frame lengths are 1..DEPTH.
- ADDR_W, 4, RAM address width; addresses are zero-extended onto the bus.
- DATA_W, 8, bus and byte width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a load; sampled only in IDLE, ignored otherwise.
- in_valid  in  1  input byte valid.
- in_data  in  DATA_W  input byte.
- in_ready  out  1  loader can accept a byte; a transfer occurs on an edge where in_valid and in_ready are both high.
- bus_drive  out  1  loader owns the bus (OR'd into the machine's external-read enable).
- bus_value  out  DATA_W  value driven on the bus; 0 when bus_drive is low.
- en_write_mem_adr  out  1  RAM address-register write strobe.
- en_write_mem  out  1  RAM data write strobe.
- cpu_hold  out  1  OR'd into the machine reset.
- busy  out  1  high in every state except IDLE, DONE and ERROR.
- done  out  1  one-cycle pulse on a successful load.
- err  out  1  sticky error flag; cleared by reset or by an accepted start.

Behaviour:
- Reset: state=IDLE. All outputs 0. Internal count, address and checksum are cleared. RAM contents are untouched.
- Frame format, in order:
  - LEN byte, valid range 1..DEPTH.
  - LEN data bytes, written to addresses 0..LEN-1.
  - SUM byte, equal to the sum of the data bytes mod 2^DATA_W.
- FSM states: IDLE, GET_LEN, GET_BYTE, WR_ADR, WR_DATA, GET_SUM, DONE, ERROR.
- IDLE: cpu_hold=0, in_ready=0. When start=1: go to GET_LEN, clear err, addr=0, sum=0. cpu_hold rises in the next cycle.
- GET_LEN: in_ready=1. On transfer:
  - LEN==0 or LEN>DEPTH: go to ERROR.
  - Otherwise latch remaining=LEN and go to GET_BYTE.
- GET_BYTE: in_ready=1. On transfer: latch the byte, add it to sum, go to WR_ADR.
- WR_ADR, exactly 1 cycle: bus_drive=1, bus_value=addr, en_write_mem_adr=1. Go to WR_DATA.
- WR_DATA, exactly 1 cycle: bus_drive=1, bus_value=latched byte, en_write_mem=1. Then addr+1, remaining-1.
  - If remaining was 1: go to GET_SUM.
  - Otherwise: go to GET_BYTE.
- Throughput: a byte accepted at edge k is written at edge k+2, and in_ready is high again in the cycle after edge k+2. Steady state is 3 cycles per byte.
- GET_SUM: in_ready=1. On transfer:
  - byte==sum: go to DONE.
  - Otherwise: go to ERROR.
- DONE: 1 cycle. done=1 and cpu_hold=1; this gives the machine at least one reset edge after the last write. Then go to IDLE, where cpu_hold=0 and the CPU starts at PC=0.
- ERROR: err=1, cpu_hold=1, in_ready=0. Stays here until start (go to GET_LEN) or reset.
- cpu_hold=1 in every state except IDLE.
- Strobes are mutually exclusive and only ever high together with bus_drive. No other bus source may be enabled while bus_drive=1, which is guaranteed because the CPU is held in reset.
- Address wrap cannot occur because LEN<=DEPTH. Sum arithmetic wraps modulo 2^DATA_W.
- in_valid while in_ready=0: the byte is not consumed; the source must hold it.
- start outside IDLE/ERROR is ignored; a frame cannot be restarted mid-load except by reset.
- Reset mid-load: back to IDLE at once and cpu_hold drops. RAM keeps any bytes already written.

Test Plan:
- Nominal load: start, then stream 03,0A,14,1E,3C with in_valid held high.
  - Expect in_ready pattern 1,1,0,0,1,0,0,1,0,0,1.
  - Expect RAM[0..2]=0A,14,1E.
  - Expect done to pulse exactly once and cpu_hold to fall one cycle after done.
- Bad checksum: frame 02,FF,02,00 (correct SUM is 01).
  - Expect RAM[0..1]=FF,02, err=1, cpu_hold held high, done never asserted.
  - A subsequent start must clear err.
- Illegal length: LEN=00 and, separately, LEN=11.
  - Expect ERROR right after the LEN transfer, no strobes ever asserted, RAM unchanged.
- Stalled source: same frame as the nominal load with in_valid low for 5 cycles between data bytes.
  - Expect the same RAM contents and checksum result, and no strobe during the stalls.
- Reset mid-load: assert reset in the WR_DATA cycle of the second byte of a 4-byte frame.
  - Expect all outputs 0 on the next cycle, RAM[0]=new value and RAM[1] written (reset only loses later bytes), state=IDLE.
- Full depth plus CPU run: load the 16-byte fib program with the correct SUM, connected to the machine.
  - Expect the machine to execute from PC=0 and OUT to show 1,1,2,3,5,8 and so on.

Source files
------------

// File: rtl/ram_loader.sv
// Program RAM loader: accepts a framed byte stream (LEN, data, SUM), writes the
// data into RAM over the shared bus and keeps the CPU in reset while doing so.
module ram_loader #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              bus_drive,
   output logic [DATA_W-1:0] bus_value,
   output logic              en_write_mem_adr,
   output logic              en_write_mem,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int CNT_W = ADDR_W + 1;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_GET_LEN  = 3'd1,
      ST_GET_BYTE = 3'd2,
      ST_WR_ADR   = 3'd3,
      ST_WR_DATA  = 3'd4,
      ST_GET_SUM  = 3'd5,
      ST_DONE     = 3'd6,
      ST_ERROR    = 3'd7
   } state_t;

   // Checksum accumulate; the sum intentionally wraps at the byte width.
   function automatic logic [DATA_W-1:0] sum_add(input logic [DATA_W-1:0] acc,
                                                  input logic [DATA_W-1:0] b);
      return acc + b;
   endfunction

   // Frame length is legal when 1..DEPTH.
   function automatic logic len_ok(input logic [DATA_W-1:0] len);
      return (len != {DATA_W{1'b0}}) && (len <= DATA_W'(DEPTH));
   endfunction

   state_t              state_r, state_s;
   logic [ADDR_W-1:0]   addr_r, addr_s;
   logic [CNT_W-1:0]    remaining_r, remaining_s;
   logic [DATA_W-1:0]   sum_r, sum_s;
   logic [DATA_W-1:0]   byte_r, byte_s;

   logic                in_ready_r, in_ready_s;
   logic                bus_drive_r, bus_drive_s;
   logic [DATA_W-1:0]   bus_value_r, bus_value_s;
   logic                adr_stb_r, adr_stb_s;
   logic                mem_stb_r, mem_stb_s;
   logic                cpu_hold_r, cpu_hold_s;
   logic                busy_r, busy_s;
   logic                done_r, done_s;
   logic                err_r, err_s;

   logic                xfer_s;

   assign xfer_s = in_valid & in_ready_r;

   // Next-state and datapath update logic.
   always_comb begin
      state_s     = state_r;
      addr_s      = addr_r;
      remaining_s = remaining_r;
      sum_s       = sum_r;
      byte_s      = byte_r;
      case (state_r)
         ST_IDLE, ST_ERROR: begin
            if (start) begin
               state_s     = ST_GET_LEN;
               addr_s      = {ADDR_W{1'b0}};
               sum_s       = {DATA_W{1'b0}};
               remaining_s = {CNT_W{1'b0}};
            end else begin
               state_s = state_r;
            end
         end
         ST_GET_LEN: begin
            if (xfer_s) begin
               if (len_ok(in_data)) begin
                  remaining_s = in_data[CNT_W-1:0];
                  state_s     = ST_GET_BYTE;
               end else begin
                  state_s = ST_ERROR;
               end
            end else begin
               state_s = ST_GET_LEN;
            end
         end
         ST_GET_BYTE: begin
            if (xfer_s) begin
               byte_s  = in_data;
               sum_s   = sum_add(sum_r, in_data);
               state_s = ST_WR_ADR;
            end else begin
               state_s = ST_GET_BYTE;
            end
         end
         ST_WR_ADR: begin
            state_s = ST_WR_DATA;
         end
         ST_WR_DATA: begin
            addr_s      = addr_r + ADDR_W'(1'b1);
            remaining_s = remaining_r - CNT_W'(1'b1);
            if (remaining_r == CNT_W'(1'b1)) begin
               state_s = ST_GET_SUM;
            end else begin
               state_s = ST_GET_BYTE;
            end
         end
         ST_GET_SUM: begin
            if (xfer_s) begin
               if (in_data == sum_r) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_ERROR;
               end
            end else begin
               state_s = ST_GET_SUM;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they can be registered
   // without adding a cycle of latency relative to the state.
   always_comb begin
      in_ready_s  = 1'b0;
      bus_drive_s = 1'b0;
      bus_value_s = {DATA_W{1'b0}};
      adr_stb_s   = 1'b0;
      mem_stb_s   = 1'b0;
      cpu_hold_s  = (state_s != ST_IDLE);
      busy_s      = 1'b0;
      done_s      = 1'b0;
      err_s       = 1'b0;
      case (state_s)
         ST_IDLE: begin
            cpu_hold_s = 1'b0;
         end
         ST_GET_LEN, ST_GET_BYTE, ST_GET_SUM: begin
            in_ready_s = 1'b1;
            busy_s     = 1'b1;
         end
         ST_WR_ADR: begin
            busy_s      = 1'b1;
            bus_drive_s = 1'b1;
            bus_value_s = {{(DATA_W-ADDR_W){1'b0}}, addr_s};
            adr_stb_s   = 1'b1;
         end
         ST_WR_DATA: begin
            busy_s      = 1'b1;
            bus_drive_s = 1'b1;
            bus_value_s = byte_s;
            mem_stb_s   = 1'b1;
         end
         ST_DONE: begin
            done_s = 1'b1;
         end
         ST_ERROR: begin
            err_s = 1'b1;
         end
         default: begin
            cpu_hold_s = 1'b1;
         end
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         addr_r      <= {ADDR_W{1'b0}};
         remaining_r <= {CNT_W{1'b0}};
         sum_r       <= {DATA_W{1'b0}};
         byte_r      <= {DATA_W{1'b0}};
         in_ready_r  <= 1'b0;
         bus_drive_r <= 1'b0;
         bus_value_r <= {DATA_W{1'b0}};
         adr_stb_r   <= 1'b0;
         mem_stb_r   <= 1'b0;
         cpu_hold_r  <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         state_r     <= state_s;
         addr_r      <= addr_s;
         remaining_r <= remaining_s;
         sum_r       <= sum_s;
         byte_r      <= byte_s;
         in_ready_r  <= in_ready_s;
         bus_drive_r <= bus_drive_s;
         bus_value_r <= bus_value_s;
         adr_stb_r   <= adr_stb_s;
         mem_stb_r   <= mem_stb_s;
         cpu_hold_r  <= cpu_hold_s;
         busy_r      <= busy_s;
         done_r      <= done_s;
         err_r       <= err_s;
      end
   end

   assign in_ready         = in_ready_r;
   assign bus_drive        = bus_drive_r;
   assign bus_value        = bus_value_r;
   assign en_write_mem_adr = adr_stb_r;
   assign en_write_mem     = mem_stb_r;
   assign cpu_hold         = cpu_hold_r;
   assign busy             = busy_r;
   assign done             = done_r;
   assign err              = err_r;

endmodule
